// File: rtl/flag_cond_unit.sv
// Architectural flag register with branch-condition resolver and a LIFO
// flag save/restore stack used on interrupt entry and exit.
module flag_cond_unit #(
    parameter int         DEPTH       = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flag_we,
    input  logic [3:0]                   i_flag,
    input  logic                         i_fr_load,
    input  logic [3:0]                   i_fr_data,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_br_valid,
    input  logic [3:0]                   i_cond,
    input  logic                         i_err_clr,
    output logic [3:0]                   o_flag,
    output logic                         o_carry,
    output logic                         o_br_valid,
    output logic                         o_br_taken,
    output logic [$clog2(DEPTH+1)-1:0]   o_sp,
    output logic                         o_ovf,
    output logic                         o_unf
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [3:0]     fr;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [3:0]     stack [2**IDXW];
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] rd_idx;

    logic push_ok, pop_ok;
    logic ovf_set, unf_set;
    logic fc, fs, fv, fz, lt;
    logic taken_c;

    assign sp_m1  = sp - 1'b1;
    assign wr_idx = sp[IDXW-1:0];
    assign rd_idx = sp_m1[IDXW-1:0];

    // A push and pop in the same cycle cancel each other and count as an underflow.
    assign push_ok = i_push & ~i_pop & (sp != SP_FULL);
    assign pop_ok  = i_pop & ~i_push & (sp != '0);
    assign ovf_set = i_push & ~i_pop & (sp == SP_FULL);
    assign unf_set = (i_pop & ~i_push & (sp == '0)) | (i_push & i_pop);

    assign fc = fr[3];
    assign fs = fr[2];
    assign fv = fr[1];
    assign fz = fr[0];
    // fs is set for non-negative results, so "negative" is ~fs.
    assign lt = ~fs ^ fv;

    always_comb begin
        taken_c = 1'b0;
        case (i_cond)
            4'h0: taken_c = 1'b1;
            4'h1: taken_c = 1'b0;
            4'h2: taken_c = ~fz;
            4'h3: taken_c = fz;
            4'h4: taken_c = fc;
            4'h5: taken_c = ~fc;
            4'h6: taken_c = ~fs;
            4'h7: taken_c = fs;
            4'h8: taken_c = fv;
            4'h9: taken_c = ~fv;
            4'hA: taken_c = fc | ~fz;
            4'hB: taken_c = ~fc & fz;
            4'hC: taken_c = lt;
            4'hD: taken_c = ~lt;
            4'hE: taken_c = lt | ~fz;
            4'hF: taken_c = ~lt & fz;
            default: taken_c = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fr         <= RESET_FLAGS;
            sp         <= '0;
            o_br_valid <= 1'b0;
            o_br_taken <= 1'b0;
            o_ovf      <= 1'b0;
            o_unf      <= 1'b0;
        end else begin
            if (pop_ok)
                fr <= stack[rd_idx];
            else if (i_fr_load)
                fr <= i_fr_data;
            else if (i_flag_we)
                fr <= i_flag;

            if (push_ok)
                sp <= sp + 1'b1;
            else if (pop_ok)
                sp <= sp_m1;

            if (ovf_set)
                o_ovf <= 1'b1;
            else if (i_err_clr)
                o_ovf <= 1'b0;

            if (unf_set)
                o_unf <= 1'b1;
            else if (i_err_clr)
                o_unf <= 1'b0;

            o_br_valid <= i_br_valid;
            o_br_taken <= i_br_valid & taken_c;
        end
    end

    // Stack contents need no reset; only sp defines what is live.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            stack[wr_idx] <= fr;
    end

    assign o_flag  = fr;
    assign o_carry = fr[3];
    assign o_sp    = sp;

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Receiving end of the ALU result interface. Captures the 4-bit ALU flag vector `{C,S,V,Z}` into the architectural flag register (FR).
- Feeds FR.C back as the ALU carry input.
- Resolves 16 branch condition codes against FR with a registered valid/taken response.
- Provides a LIFO flag save/restore stack for interrupt entry and exit.

Parameters:
- DEPTH, 4, number of entries in the flag save stack (1..16).
- RESET_FLAGS, 4'b0000, value loaded into FR on reset.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_flag_we  input  1  capture i_flag into FR this cycle
- i_flag  input  4  ALU flag vector `{C,S,V,Z}`, ALU polarity
- i_fr_load  input  1  software write of FR from i_fr_data
- i_fr_data  input  4  software FR value
- i_push  input  1  save FR onto stack
- i_pop  input  1  restore FR from stack top
- i_br_valid  input  1  branch condition request
- i_cond  input  4  condition code
- i_err_clr  input  1  clear sticky error bits
- o_flag  output  4  current FR
- o_carry  output  1  FR[3], drives ALU i_carry
- o_br_valid  output  1  branch response valid
- o_br_taken  output  1  condition result
- o_sp  output  $clog2(DEPTH+1)  stack occupancy
- o_ovf  output  1  sticky: push while full
- o_unf  output  1  sticky: pop while empty, or push+pop collision

Behaviour:
- Flag polarity (ALU native):
  - fc = FR[3]: carry out, or borrow on SUB/DEC.
  - fs = FR[2]: 1 = result bit15 clear (non-negative).
  - fv = FR[1]: overflow.
  - fz = FR[0]: 1 = 17-bit ALU result nonzero.
  - No inversion is applied on capture.
- Reset (i_rst_n low, asynchronous, any cycle, including mid-push/pop or branch):
  - FR = RESET_FLAGS; o_carry = RESET_FLAGS[3].
  - o_sp = 0; o_br_valid = 0; o_br_taken = 0; o_ovf = 0; o_unf = 0.
  - Stack contents are don't-care.
- FR update priority per cycle, highest first:
  1. Valid pop
  2. i_fr_load
  3. i_flag_we
- Update latency: the new FR is visible on o_flag and o_carry the cycle after the write.
- Push (i_push = 1, i_pop = 0):
  - If o_sp < DEPTH: stack[o_sp] <= FR value before any same-cycle update; o_sp increments.
  - If full: stack and o_sp unchanged; o_ovf <= 1. A same-cycle FR update still proceeds.
- Pop (i_pop = 1, i_push = 0):
  - If o_sp > 0: FR <= stack[o_sp-1]; o_sp decrements. Overrides same-cycle load or flag_we.
  - If empty: o_sp unchanged, FR follows load/flag_we normally; o_unf <= 1.
- Push and pop in the same cycle:
  - Stack and o_sp unchanged; o_unf <= 1.
  - FR follows load/flag_we normally.
- Sticky errors:
  - o_ovf and o_unf hold until i_err_clr.
  - If an error event and i_err_clr occur in the same cycle, the set wins.
- Branch resolve:
  - A request with i_br_valid at edge N gives o_br_valid = 1 for exactly one cycle after N.
  - o_br_taken = cond(i_cond, FR as it stood before edge N), ignoring same-cycle FR writes.
  - When o_br_valid = 0, o_br_taken = 0.
  - Back-to-back requests every cycle are supported; there is no stall.
- Condition codes, with lt = ~fs ^ fv:

| Code | Mnemonic | Taken when |
|---|---|---|
| 0 | AL | 1 |
| 1 | NV | 0 |
| 2 | EQ | ~fz |
| 3 | NE | fz |
| 4 | LTU | fc |
| 5 | GEU | ~fc |
| 6 | MI | ~fs |
| 7 | PL | fs |
| 8 | VS | fv |
| 9 | VC | ~fv |
| A | LEU | fc \| ~fz |
| B | GTU | ~fc & fz |
| C | LT | lt |
| D | GE | ~lt |
| E | LE | lt \| ~fz |
| F | GT | ~lt & fz |

Test Plan:
1. Reset: assert i_rst_n low mid-push with o_sp = 2 → o_flag = 0000, o_sp = 0, o_br_valid = 0, o_ovf = o_unf = 0, all asynchronously.
2. Flag capture: i_flag_we with i_flag = 4'b1001 (3−5) → o_flag = 1001 and o_carry = 1 next cycle. Then br_valid with LTU, LT and NE → taken = 1 each. EQ and GEU → taken = 0.
3. Flag capture, other direction: i_flag = 4'b0101 (5−3) → GTU = 1, GT = 1, LEU = 0, PL = 1. Sweep all 16 codes against FR = 0000, 1111 and 0110 and compare with the condition table.
4. Stack order: with DEPTH = 4, push FR values A, B, C, D (o_sp reaches 4). A 5th push → o_ovf = 1, o_sp stays 4. Four pops restore D, C, B, A. A 5th pop → o_unf = 1, FR unchanged.
5. Simultaneous events:
   - push + flag_we(0101) with FR = 1001 → stack top = 1001, FR = 0101.
   - pop + i_fr_load(1111) → FR = popped value.
   - push + pop → o_sp unchanged, o_unf = 1.
   - i_err_clr → o_ovf = o_unf = 0 next cycle.
6. Branch ordering: br_valid(EQ) in the same cycle as flag_we(0000) with FR = 0001 → o_br_taken = 0 (old FR used). Next request → taken = 1.
